// File: rtl/matrix_mem_stream.sv
// M x N matrix store: element writes, whole-matrix zero-fill, and row/column
// streaming through a single-read-port synchronous RAM onto a valid/ready output.
module matrix_mem_stream #(
    parameter int unsigned DW = 16,
    parameter int unsigned M  = 8,
    parameter int unsigned N  = 8,
    localparam int unsigned RW = $clog2(M),
    localparam int unsigned CW = $clog2(N),
    localparam int unsigned IW = (RW > CW) ? RW : CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_row,
    input  logic [CW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_mode,
    input  logic [IW-1:0] cmd_index,
    input  logic          clr_start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          err
);

    localparam int unsigned DEPTH = M * N;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LMAX  = (M > N) ? M : N;
    localparam int unsigned KW    = $clog2(LMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] clr_cnt;

    logic [KW-1:0] iss_cnt;
    logic [KW-1:0] len;
    logic          mode_q;
    logic [IW-1:0] idx_q;
    logic          s1_valid;
    logic          s1_last;

    logic cmd_acc;
    logic cmd_bad;
    logic s2_en;
    logic issue;
    logic done;

    assign cmd_acc = cmd_valid && cmd_ready;
    assign cmd_bad = cmd_mode ? (32'(cmd_index) >= N) : (32'(cmd_index) >= M);
    assign s2_en   = !out_valid || out_ready;
    assign done    = out_valid && out_ready && out_last;
    assign wr_addr = AW'(AW'(wr_row) * AW'(N) + AW'(wr_col));

    // Row mode walks columns of idx_q; column mode walks rows.
    assign ram_raddr = mode_q ? AW'(AW'(iss_cnt) * AW'(N) + AW'(idx_q))
                              : AW'(AW'(idx_q) * AW'(N) + AW'(iss_cnt));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (clr_start)                   state_nx = CLEAR;
                else if (cmd_valid && !cmd_bad)  state_nx = STREAM;
            end
            STREAM: if (done) state_nx = IDLE;
            CLEAR:  if (clr_cnt == AW'(DEPTH - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !clr_start;
                ram_we    = wr_en;
            end
            STREAM: begin
                ram_we = wr_en;
                issue  = (iss_cnt != len) && (!s1_valid || s2_en);
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = '0;
            end
            default: ;
        endcase
        if (rst) ram_we = 1'b0;
    end

    // Read-first RAM: a read in the same cycle as a write returns the old word.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (issue)  ram_q <= mem[ram_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_cnt   <= '0;
            len       <= '0;
            mode_q    <= 1'b0;
            idx_q     <= '0;
            clr_cnt   <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            err  <= cmd_acc && cmd_bad;
            busy <= (state_nx != IDLE);

            if (cmd_acc && !cmd_bad) begin
                mode_q  <= cmd_mode;
                idx_q   <= cmd_index;
                iss_cnt <= '0;
                len     <= cmd_mode ? KW'(M) : KW'(N);
            end else if (issue) begin
                iss_cnt <= iss_cnt + KW'(1);
            end

            if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
            else                clr_cnt <= '0;

            // Stage 1 holds the RAM word; it refills only when it can drain.
            if (issue) begin
                s1_valid <= 1'b1;
                s1_last  <= (iss_cnt == len - KW'(1));
            end else if (s2_en) begin
                s1_valid <= 1'b0;
            end

            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= ram_q;
                    out_last <= s1_last;
                end else begin
                    out_last <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_mem_stream.sv
// Bench for matrix_mem_stream: 4x4 instance for streaming/clear/reset cases,
// 4x8 instance for the out-of-range command case.
module tb_matrix_mem_stream;

    logic clk = 1'b0;
    logic rst;

    logic        wr_en;
    logic [1:0]  wr_row, wr_col;
    logic [15:0] wr_data;
    logic        cmd_valid, cmd_ready, cmd_mode;
    logic [1:0]  cmd_index;
    logic        clr_start;
    logic        out_valid, out_ready, out_last, busy, err;
    logic [15:0] out_data;

    logic        d2_wr_en;
    logic [1:0]  d2_wr_row;
    logic [2:0]  d2_wr_col;
    logic [15:0] d2_wr_data;
    logic        d2_cmd_valid, d2_cmd_ready, d2_cmd_mode;
    logic [2:0]  d2_cmd_index;
    logic        d2_clr_start;
    logic        d2_out_valid, d2_out_ready, d2_out_last, d2_busy, d2_err;
    logic [15:0] d2_out_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [16];

    typedef struct packed {
        logic            mode;
        logic [1:0]      idx;
        logic [1:0]      rdy;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    matrix_mem_stream #(.DW(16), .M(4), .N(4)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_index(cmd_index), .clr_start(clr_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err)
    );

    matrix_mem_stream #(.DW(16), .M(4), .N(8)) dut2 (
        .clk(clk), .rst(rst),
        .wr_en(d2_wr_en), .wr_row(d2_wr_row), .wr_col(d2_wr_col), .wr_data(d2_wr_data),
        .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_mode(d2_cmd_mode),
        .cmd_index(d2_cmd_index), .clr_start(d2_clr_start),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
        .out_last(d2_out_last), .busy(d2_busy), .err(d2_err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_elem(input int r, input int c, input logic [15:0] d);
        wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
        step();
        wr_en = 1'b0;
        model[4'(r * 4 + c)] = d;
    endtask

    function automatic vec_t mkv(input logic m, input logic [1:0] i, input logic [1:0] r,
                                 input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [15:0] e2, input logic [15:0] e3);
        vec_t v;
        v.mode = m; v.idx = i; v.rdy = r;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    function automatic logic [15:0] model_elem(input logic mode, input int idx, input int i);
        return mode ? model[4'(i * 4 + idx)] : model[4'(idx * 4 + i)];
    endfunction

    // rdy_kind: 0 always ready, 1 ready on k%3==2, 2 random.
    task automatic run_stream(input logic mode, input int idx, input int rdy_kind,
                              input int inj_k, input int inj_addr, input logic [15:0] inj_data,
                              input int rst_after,
                              output int n_got, output logic [3:0][15:0] got,
                              output int lat, output int last_pos, output int span);
        logic held, held_last, done, hs;
        logic [15:0] held_data;
        int first_hs, last_hs;
        n_got = 0; got = '0; lat = -1; last_pos = -1; span = -1;
        held = 1'b0; held_last = 1'b0; held_data = '0; done = 1'b0;
        first_hs = -1; last_hs = -1;
        cmd_valid = 1'b1; cmd_mode = mode; cmd_index = 2'(idx); out_ready = 1'b0;
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (out_valid && lat < 0) lat = k;
            if (held) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(held_data));
                chk("stall_last", 32'(out_last), 32'(held_last));
            end
            wr_en = (k == inj_k); wr_row = 2'(inj_addr / 4); wr_col = 2'(inj_addr % 4);
            wr_data = inj_data;
            case (rdy_kind)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 2);
                default: out_ready = 1'($urandom);
            endcase
            hs = out_valid && out_ready;
            if (hs) begin
                if (n_got < 4) got[2'(n_got)] = out_data;
                if (out_last) last_pos = n_got;
                n_got++;
                if (first_hs < 0) first_hs = k;
                last_hs = k;
                done = out_last;
            end
            held = out_valid && !out_ready; held_data = out_data; held_last = out_last;
            if (hs && rst_after > 0 && n_got == rst_after) begin
                rst = 1'b1;
                done = 1'b1;
            end
            step();
            wr_en = 1'b0;
        end
        out_ready = 1'b0;
        span = last_hs - first_hs;
        chk("stream_end", 32'(done), 32'd1);
    endtask

    task automatic do_clear(input logic with_cmd, input logic inject);
        int cnt;
        clr_start = 1'b1; cmd_valid = with_cmd; cmd_mode = 1'b0; cmd_index = 2'd0;
        #1;
        chk("clr_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        clr_start = 1'b0; cmd_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) cnt++;
            wr_en = inject && (k == 5); wr_row = 2'd0; wr_col = 2'd0; wr_data = 16'hAAAA;
            step();
            wr_en = 1'b0;
        end
        chk("clr_busy_cycles", 32'(cnt), 32'd16);
        chk("clr_no_output", 32'(out_valid), 32'd0);
        for (int a = 0; a < 16; a++) model[4'(a)] = 16'h0;
    endtask

    initial begin
        int n_got, lat, last_pos, span, cnt;
        logic [3:0][15:0] got;

        rst = 1'b1;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_index = '0; clr_start = 1'b0; out_ready = 1'b0;
        d2_wr_en = 1'b0; d2_wr_row = '0; d2_wr_col = '0; d2_wr_data = '0;
        d2_cmd_valid = 1'b0; d2_cmd_mode = 1'b0; d2_cmd_index = '0;
        d2_clr_start = 1'b0; d2_out_ready = 1'b0;
        for (int a = 0; a < 16; a++) model[4'(a)] = 16'h0;

        step(); step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_d2_busy", 32'(d2_busy), 32'd0);
        rst = 1'b0;
        step();

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                wr_elem(r, c, 16'(16 * r + c));

        tbl[0] = mkv(1'b0, 2'd2, 2'd0, 16'h20, 16'h21, 16'h22, 16'h23);
        tbl[1] = mkv(1'b1, 2'd1, 2'd1, 16'h01, 16'h11, 16'h21, 16'h31);
        tbl[2] = mkv(1'b0, 2'd0, 2'd2, 16'h00, 16'h01, 16'h02, 16'h03);
        tbl[3] = mkv(1'b1, 2'd3, 2'd0, 16'h03, 16'h13, 16'h23, 16'h33);
        tbl[4] = mkv(1'b0, 2'd3, 2'd1, 16'h30, 16'h31, 16'h32, 16'h33);

        for (int v = 0; v < 5; v++) begin
            run_stream(tbl[3'(v)].mode, int'(tbl[3'(v)].idx), int'(tbl[3'(v)].rdy),
                       -1, 0, 16'h0, 0, n_got, got, lat, last_pos, span);
            chk($sformatf("tbl%0d_count", v), 32'(n_got), 32'd4);
            chk($sformatf("tbl%0d_latency", v), 32'(lat), 32'd2);
            chk($sformatf("tbl%0d_last_pos", v), 32'(last_pos), 32'd3);
            for (int i = 0; i < 4; i++)
                chk($sformatf("tbl%0d_elem%0d", v, i), 32'(got[2'(i)]), 32'(tbl[3'(v)].exp[2'(i)]));
            if (tbl[3'(v)].rdy == 2'd0)
                chk($sformatf("tbl%0d_no_bubble", v), 32'(span), 32'd3);
            chk($sformatf("tbl%0d_busy_after", v), 32'(busy), 32'd0);
            chk($sformatf("tbl%0d_ready_after", v), 32'(cmd_ready), 32'd1);
        end

        // Write lands one cycle before (0,3) is read: visible in the stream.
        run_stream(1'b0, 0, 0, 2, 3, 16'hBEEF, 0, n_got, got, lat, last_pos, span);
        chk("early_write_e0", 32'(got[0]), 32'h00);
        chk("early_write_e3", 32'(got[3]), 32'hBEEF);
        model[4'd3] = 16'hBEEF;
        // Write in the same cycle as the read: old data comes out.
        run_stream(1'b0, 0, 0, 3, 3, 16'h1234, 0, n_got, got, lat, last_pos, span);
        chk("same_cycle_write_e3", 32'(got[3]), 32'hBEEF);
        model[4'd3] = 16'h1234;
        run_stream(1'b0, 0, 0, -1, 0, 16'h0, 0, n_got, got, lat, last_pos, span);
        chk("same_cycle_write_landed", 32'(got[3]), 32'h1234);

        // Reset in the middle of a row stream.
        run_stream(1'b0, 1, 0, -1, 0, 16'h0, 2, n_got, got, lat, last_pos, span);
        chk("abort_count", 32'(n_got), 32'd2);
        chk("abort_e1", 32'(got[1]), 32'(model[4'd5]));
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_data", 32'(out_data), 32'd0);
        chk("abort_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        run_stream(1'b0, 1, 0, -1, 0, 16'h0, 0, n_got, got, lat, last_pos, span);
        for (int i = 0; i < 4; i++)
            chk($sformatf("reread_e%0d", i), 32'(got[2'(i)]), 32'(model_elem(1'b0, 1, i)));

        // Reset two writes into a clear: only addresses 0 and 1 are zeroed.
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        chk("clr_abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model[4'd0] = 16'h0; model[4'd1] = 16'h0;
        run_stream(1'b0, 0, 0, -1, 0, 16'h0, 0, n_got, got, lat, last_pos, span);
        for (int i = 0; i < 4; i++)
            chk($sformatf("partial_clr_e%0d", i), 32'(got[2'(i)]), 32'(model_elem(1'b0, 0, i)));

        // Clear with a simultaneous command and a write attempt during the fill.
        do_clear(1'b1, 1'b1);
        run_stream(1'b0, 3, 0, -1, 0, 16'h0, 0, n_got, got, lat, last_pos, span);
        for (int i = 0; i < 4; i++)
            chk($sformatf("clr_row3_e%0d", i), 32'(got[2'(i)]), 32'h0);
        run_stream(1'b0, 0, 0, -1, 0, 16'h0, 0, n_got, got, lat, last_pos, span);
        chk("clr_ignores_write", 32'(got[0]), 32'h0);

        // Out-of-range row on the 4x8 instance.
        d2_cmd_valid = 1'b1; d2_cmd_mode = 1'b0; d2_cmd_index = 3'd5;
        #1;
        chk("oor_cmd_ready", 32'(d2_cmd_ready), 32'd1);
        step();
        d2_cmd_valid = 1'b0;
        chk("oor_err_pulse", 32'(d2_err), 32'd1);
        chk("oor_busy", 32'(d2_busy), 32'd0);
        cnt = 0;
        step();
        chk("oor_err_single", 32'(d2_err), 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (d2_out_valid || d2_busy) cnt++;
            step();
        end
        chk("oor_no_output", 32'(cnt), 32'd0);
        chk("oor_ready_after", 32'(d2_cmd_ready), 32'd1);

        // Randomized writes, clears and streams against the array model.
        for (int it = 0; it < 30; it++) begin
            int nw;
            logic m;
            int ix;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                wr_elem($urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
            if ($urandom_range(0, 9) == 0) do_clear(1'b0, 1'b0);
            m = 1'($urandom);
            ix = $urandom_range(0, 3);
            run_stream(m, ix, ($urandom_range(0, 1) == 0) ? 0 : 2, -1, 0, 16'h0, 0,
                       n_got, got, lat, last_pos, span);
            chk("rnd_count", 32'(n_got), 32'd4);
            chk("rnd_last_pos", 32'(last_pos), 32'd3);
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd%0d_e%0d", it, i), 32'(got[2'(i)]), 32'(model_elem(m, ix, i)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_mem_stream.md
MATRIX_MEM_STREAM -- requirements
Module: matrix_mem_stream

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning element data width in bits.
REQ-002 The block SHALL have parameter M, default 8, meaning row count; M >= 2.
REQ-003 The block SHALL have parameter N, default 8, meaning column count; N >= 2.
REQ-004 The block SHALL define derived widths RW=$clog2(M), CW=$clog2(N) and IW=max(RW,CW).
REQ-005 The block SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-006 Ports SHALL be exactly:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  element write strobe
- wr_row  in  RW  write row
- wr_col  in  CW  write column
- wr_data  in  DW  write data
- cmd_valid  in  1  stream command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_mode  in  1  0 = stream row, 1 = stream column
- cmd_index  in  IW  row or column number
- clr_start  in  1  request zero-fill of the whole matrix
- out_valid  out  1  out_data holds an element
- out_ready  in  1  consumer accepts element
- out_data  out  DW  streamed element
- out_last  out  1  final element of the current stream
- busy  out  1  FSM not IDLE
- err  out  1  one-cycle pulse, out-of-range command

Function
REQ-007 Storage SHALL be M*N words of DW bits, linear address row*N+col, synchronous single-read-port RAM.
REQ-008 The FSM SHALL have states IDLE, STREAM, CLEAR.
REQ-009 cmd_ready SHALL equal 1 only in IDLE and with clr_start low.
REQ-010 In IDLE, clr_start high SHALL enter CLEAR and take priority over a simultaneous cmd_valid.
REQ-011 CLEAR SHALL write zero to addresses 0..M*N-1, one per cycle, then return to IDLE; it SHALL last exactly M*N cycles.
REQ-012 During CLEAR, wr_en SHALL be ignored.
REQ-013 An accepted command with cmd_index >= M (mode 0) or >= N (mode 1) SHALL pulse err for one cycle the next cycle, produce no output, and remain in IDLE.
REQ-014 A valid accepted command SHALL enter STREAM; row mode emits (idx,0)..(idx,N-1), column mode emits (0,idx)..(M-1,idx).
REQ-015 The first out_valid SHALL assert two cycles after the acceptance edge: one address-issue cycle, then one RAM latency cycle.
REQ-016 With out_ready held high, one element SHALL be emitted per cycle, with no bubbles.
REQ-017 When out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable and no element SHALL be skipped or duplicated.
REQ-018 out_last SHALL be high with the final element only; after that element is accepted, the FSM SHALL return to IDLE the same cycle.
REQ-019 The next command SHALL be accepted no earlier than the cycle after the FSM returns to IDLE.
REQ-020 wr_en SHALL be honoured in IDLE and STREAM.
REQ-021 A same-cycle write and read of one address SHALL return old data (read-first).
REQ-022 A write to an element not yet read in the active stream SHALL be visible in that stream.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 rst SHALL force state IDLE, and force out_valid, out_last, err and busy to 0, with out_data = 0.
REQ-025 rst asserted mid-STREAM or mid-CLEAR SHALL abort the operation immediately; the next cycle SHALL show IDLE with no output.
REQ-026 RAM contents SHALL NOT be reset; an aborted CLEAR leaves the matrix partially zeroed.

Verification (M=N=4, DW=16)
REQ-027 Write elem(r,c)=16*r+c, row command idx=2, out_ready=1 -> 0x20,0x21,0x22,0x23 on consecutive cycles, out_last on 0x23, first out_valid 2 cycles after accept.
REQ-028 Column command idx=1 with out_ready toggled 1,0,0,1,... -> 0x01,0x11,0x21,0x31 in order, data stable while stalled, no duplicates.
REQ-029 clr_start and cmd_valid in the same IDLE cycle -> cmd_ready=0, busy high exactly 16 cycles; a subsequent row command idx=3 -> four 0x0000 elements.
REQ-030 Row command idx=5 (IW=2, so use M=4,N=8 build, idx=5) -> err single pulse, no out_valid, FSM stays IDLE.
REQ-031 rst pulsed after the second element of a row stream -> next cycle out_valid=0, busy=0, cmd_ready=1; RAM data intact on re-read.
REQ-032 During row stream idx=0, write (0,3)=0xBEEF one cycle before (0,3) is read -> last element 0xBEEF; write to (0,3) in its read cycle -> old value.
